// File: rtl/mer_sequencer_if.sv
// Bundles the control handshake and status outputs of the MER measurement
// sequencer. The master modport is the consumer/controller side. The slave
// modport is the sequencer itself.
interface mer_sequencer_if #(
    parameter int SYM_W = 16
) ();
    logic             start;
    logic             abort;
    logic [1:0]       len_sel;
    logic             result_ack;
    logic             smp_en;
    logic             int_en;
    logic             sym_en;
    logic             clear_accum;
    logic             accum_en;
    logic             busy;
    logic             done;
    logic [SYM_W-1:0] sym_count;

    modport master (
        output start, abort, len_sel, result_ack,
        input  smp_en, int_en, sym_en, clear_accum, accum_en, busy, done, sym_count
    );

    modport slave (
        input  start, abort, len_sel, result_ack,
        output smp_en, int_en, sym_en, clear_accum, accum_en, busy, done, sym_count
    );
endinterface

// File: rtl/mer_sequencer.sv
// MER measurement sequencer. A free-running 4-bit phase counter derives the
// sample, interpolation and symbol rate strobes. A five-state FSM aligns each
// measurement to a symbol boundary. It then clears the accumulators, integrates
// for N = 256 << (2*len_sel) symbols and holds the results until acknowledged.
module mer_sequencer #(
    parameter int SYM_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    mer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        CLEAR = 3'd2,
        ACCUM = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       phase_r;
    logic [1:0]       len_r;
    logic [1:0]       len_next_s;
    logic [SYM_W-1:0] sym_count_r;
    logic [SYM_W-1:0] sym_count_next_s;
    logic [SYM_W-1:0] target_m1_s;
    logic             sym_tick_s;
    logic             capture_s;
    logic             kill_s;
    logic             clear_accum_r;
    logic             accum_en_r;
    logic             busy_r;
    logic             done_r;
    logic             clear_accum_next_s;
    logic             accum_en_next_s;
    logic             busy_next_s;
    logic             done_next_s;

    // Free-running phase counter. Only reset touches it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_r <= 4'd0;
        end else begin
            phase_r <= phase_r + 4'd1;
        end
    end

    // Rate strobes decode straight from the phase so they line up with it exactly.
    assign bus.smp_en = (phase_r[1:0] == 2'b11);
    assign bus.int_en = phase_r[0];
    assign bus.sym_en = (phase_r == 4'hF);
    assign sym_tick_s = (phase_r == 4'hF);

    // Last symbol index (N-1) for the captured measurement length.
    always_comb begin
        target_m1_s = SYM_W'(16'd255);
        case (len_r)
            2'd0:    target_m1_s = SYM_W'(16'd255);
            2'd1:    target_m1_s = SYM_W'(16'd1023);
            2'd2:    target_m1_s = SYM_W'(16'd4095);
            2'd3:    target_m1_s = SYM_W'(16'd16383);
            default: target_m1_s = SYM_W'(16'd255);
        endcase
    end

    // Abort cancels any active state. A start is accepted from IDLE, or from HOLD
    // together with an acknowledge. Abort always wins over both.
    always_comb begin
        kill_s    = bus.abort && (state_r != IDLE);
        capture_s = 1'b0;
        if (bus.abort) begin
            capture_s = 1'b0;
        end else if (state_r == IDLE) begin
            capture_s = bus.start;
        end else if (state_r == HOLD) begin
            capture_s = bus.start && bus.result_ack;
        end else begin
            capture_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    state_next_s = ALIGN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ALIGN: begin
                if (kill_s) begin
                    state_next_s = IDLE;
                end else if (sym_tick_s) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = ALIGN;
                end
            end
            CLEAR: begin
                if (kill_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            ACCUM: begin
                if (kill_s) begin
                    state_next_s = IDLE;
                end else if (sym_tick_s && (sym_count_r == target_m1_s)) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (kill_s) begin
                    state_next_s = IDLE;
                end else if (capture_s) begin
                    state_next_s = ALIGN;
                end else if (bus.result_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output logic. It computes the next-cycle values of the registered
    // outputs, the symbol count and the captured length.
    always_comb begin
        len_next_s       = len_r;
        sym_count_next_s = sym_count_r;
        if (kill_s) begin
            sym_count_next_s = '0;
        end else if (capture_s) begin
            sym_count_next_s = '0;
            len_next_s       = bus.len_sel;
        end else if ((state_r == ACCUM) && sym_tick_s) begin
            sym_count_next_s = sym_count_r + SYM_W'(1'b1);
        end else begin
            sym_count_next_s = sym_count_r;
        end
        clear_accum_next_s = (state_next_s == CLEAR);
        accum_en_next_s    = (state_next_s == ACCUM);
        busy_next_s        = (state_next_s == ALIGN) || (state_next_s == CLEAR) ||
                             (state_next_s == ACCUM);
        done_next_s        = (state_next_s == HOLD);
    end

    // Output, symbol-count and length-capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r         <= 2'd0;
            sym_count_r   <= '0;
            clear_accum_r <= 1'b0;
            accum_en_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            len_r         <= len_next_s;
            sym_count_r   <= sym_count_next_s;
            clear_accum_r <= clear_accum_next_s;
            accum_en_r    <= accum_en_next_s;
            busy_r        <= busy_next_s;
            done_r        <= done_next_s;
        end
    end

    assign bus.clear_accum = clear_accum_r;
    assign bus.accum_en    = accum_en_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.sym_count   = sym_count_r;

endmodule

// File: tb/tb_mer_sequencer.sv
// Self-checking bench for mer_sequencer. A timeline model tracks measurements
// as absolute cycle numbers. It records the accept cycle, the clear cycle and
// the length, and derives every expected output arithmetically for each cycle.
module tb_mer_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #20 clk = ~clk;

    mer_sequencer_if #(.SYM_W(16)) bus_if ();

    mer_sequencer #(.SYM_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Timeline model: cyc counts rising edges since reset release.
    // m_mode: 0 idle, 1 measurement in flight, 2 results held.
    int cyc;
    int m_mode;
    int m_clr;
    int m_n;
    int m_count;

    int clr_pulses;
    int acc_cycles;
    int smp_cnt;
    int int_cnt;
    int sym_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {9'd0, bus_if.smp_en, bus_if.int_en, bus_if.sym_en, bus_if.clear_accum,
                bus_if.accum_en, bus_if.busy, bus_if.done, bus_if.sym_count};
    endfunction

    function automatic logic [31:0] model_outs();
        int ph;
        int cnt;
        logic smp, intr, sym, clr, acc, bsy, dn;
        ph   = cyc % 16;
        smp  = ((ph % 4) == 3);
        intr = ((ph % 2) == 1);
        sym  = (ph == 15);
        clr  = 1'b0;
        acc  = 1'b0;
        bsy  = 1'b0;
        dn   = 1'b0;
        cnt  = m_count;
        if (m_mode == 1) begin
            bsy = 1'b1;
            clr = (cyc == m_clr);
            acc = (cyc > m_clr);
            cnt = (cyc > m_clr) ? (cyc - m_clr) / 16 : 0;
        end else if (m_mode == 2) begin
            dn = 1'b1;
        end
        return {9'd0, smp, intr, sym, clr, acc, bsy, dn, cnt[15:0]};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (m_mode != 0 && bus_if.abort) begin
            m_mode  = 0;
            m_count = 0;
        end else if (bus_if.start && !bus_if.abort &&
                     (m_mode == 0 || (m_mode == 2 && bus_if.result_ack))) begin
            m_mode  = 1;
            m_n     = 256 << (2 * int'(bus_if.len_sel));
            m_clr   = ((cyc + 2 + 15) / 16) * 16;   // first phase-0 cycle after one ALIGN cycle
            m_count = 0;
        end else if (m_mode == 2 && bus_if.result_ack) begin
            m_mode = 0;
        end
        cyc++;
        if (m_mode == 1 && cyc == m_clr + 16 * m_n) begin
            m_mode  = 2;
            m_count = m_n;
        end
        #1;
        check_eq("outs", dut_outs(), model_outs());
        if (bus_if.clear_accum) clr_pulses++;
        if (bus_if.accum_en)    acc_cycles++;
        if (bus_if.smp_en)      smp_cnt++;
        if (bus_if.int_en)      int_cnt++;
        if (bus_if.sym_en)      sym_cnt++;
    endtask

    task automatic apply_reset(input int edges);
        reset          = 1'b0;
        bus_if.start   = 1'b1;
        cyc     = 0;
        m_mode  = 0;
        m_count = 0;
        #1;
        check_eq("rst_async", dut_outs(), model_outs());
        repeat (edges) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold", dut_outs(), model_outs());
        end
        bus_if.start      = 1'b0;
        bus_if.abort      = 1'b0;
        bus_if.result_ack = 1'b0;
        reset             = 1'b1;
        #1;
        check_eq("rst_rel", dut_outs(), model_outs());
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (bus_if.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check_eq("done_wait", {31'd0, bus_if.done}, 32'd1);
    endtask

    task automatic pulse_start(input logic [1:0] len, input logic ack);
        bus_if.start      = 1'b1;
        bus_if.len_sel    = len;
        bus_if.result_ack = ack;
        tick();
        bus_if.start      = 1'b0;
        bus_if.result_ack = 1'b0;
    endtask

    initial begin
        int n;
        bus_if.start      = 1'b0;
        bus_if.abort      = 1'b0;
        bus_if.len_sel    = 2'd0;
        bus_if.result_ack = 1'b0;

        // Reset with start held high, which must be ignored.
        apply_reset(3);

        // Strobe pattern over cycles 0..31.
        smp_cnt = bus_if.smp_en ? 1 : 0;
        int_cnt = bus_if.int_en ? 1 : 0;
        sym_cnt = bus_if.sym_en ? 1 : 0;
        repeat (31) tick();
        check_eq("smp_cnt", smp_cnt, 32'd8);
        check_eq("int_cnt", int_cnt, 32'd16);
        check_eq("sym_cnt", sym_cnt, 32'd2);

        // Abort in ACCUM at sym_count == 100.
        while (cyc % 16 != 5) tick();
        pulse_start(2'd0, 1'b0);
        n = 0;
        while (!(bus_if.accum_en && bus_if.sym_count == 16'd100) && n < 3000) begin
            tick();
            n++;
        end
        check_eq("reach_100", {16'd0, bus_if.sym_count}, 32'd100);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        check_eq("abort_cnt", {16'd0, bus_if.sym_count}, 32'd0);
        check_eq("abort_busy", {31'd0, bus_if.busy}, 32'd0);

        // Basic len_sel=0 run started at phase 5.
        while (cyc % 16 != 5) tick();
        clr_pulses = 0;
        acc_cycles = 0;
        pulse_start(2'd0, 1'b0);
        wait_done(16 * 256 + 64);
        check_eq("basic_cnt", {16'd0, bus_if.sym_count}, 32'd256);
        check_eq("basic_clr", clr_pulses, 32'd1);
        // ACCUM runs from phase 1 after CLEAR up to and including the 256th phase-15 strobe.
        check_eq("basic_acc", acc_cycles, 32'd4095);

        // Start without acknowledge in HOLD is ignored.
        bus_if.start = 1'b1;
        repeat (4) tick();
        bus_if.start = 1'b0;
        check_eq("hold_ign", {31'd0, bus_if.done}, 32'd1);

        // Acknowledge and start together restart with len_sel=1.
        clr_pulses = 0;
        pulse_start(2'd1, 1'b1);
        check_eq("ackst_busy", {30'd0, bus_if.busy, bus_if.done}, 32'd2);
        wait_done(16 * 1024 + 64);
        check_eq("ackst_cnt", {16'd0, bus_if.sym_count}, 32'd1024);
        check_eq("ackst_clr", clr_pulses, 32'd1);

        // Plain acknowledge returns to idle.
        bus_if.result_ack = 1'b1;
        tick();
        bus_if.result_ack = 1'b0;
        check_eq("ack_idle", {30'd0, bus_if.busy, bus_if.done}, 32'd0);

        // Length captured at start. A later len_sel change has no effect.
        pulse_start(2'd2, 1'b0);
        repeat (100) tick();
        bus_if.len_sel = 2'd0;
        wait_done(16 * 4096 + 64);
        check_eq("len_cap", {16'd0, bus_if.sym_count}, 32'd4096);
        bus_if.result_ack = 1'b1;
        tick();
        bus_if.result_ack = 1'b0;

        // Randomized control traffic.
        repeat (1200) begin
            bus_if.start      = ($urandom % 8) == 0;
            bus_if.abort      = ($urandom % 16) == 0;
            bus_if.result_ack = ($urandom % 4) == 0;
            bus_if.len_sel    = 2'($urandom % 4);
            tick();
        end
        bus_if.start      = 1'b0;
        bus_if.result_ack = 1'b0;
        bus_if.abort      = 1'b1;
        tick();
        bus_if.abort = 1'b0;

        // Reset in the middle of ACCUM.
        pulse_start(2'd0, 1'b0);
        n = 0;
        while (!bus_if.accum_en && n < 64) begin
            tick();
            n++;
        end
        check_eq("pre_rst_acc", {31'd0, bus_if.accum_en}, 32'd1);
        repeat (40) tick();
        #5;
        apply_reset(3);
        repeat (3) tick();
        check_eq("rst_phase", {29'd0, bus_if.smp_en, bus_if.int_en, bus_if.sym_en}, 32'd6);
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
